// File: rtl/timer_event_pkg.sv
// Shared register map, bit positions and FSM encoding for timer_event.
package timer_event_pkg;

   localparam logic [7:0] ADDR_CTRL    = 8'h08;
   localparam logic [7:0] ADDR_STATUS  = 8'h09;
   localparam logic [7:0] ADDR_ACK     = 8'h0a;
   localparam logic [7:0] ADDR_COUNT   = 8'h0b;
   localparam logic [7:0] ADDR_COMPARE = 8'h0c;

   localparam int CTRL_IRQ_EN_BIT  = 0;
   localparam int CTRL_CMP_EN_BIT  = 1;
   localparam int STAT_PENDING_BIT = 0;
   localparam int STAT_OVERRUN_BIT = 1;
   localparam int STAT_RUN_BIT     = 2;
   localparam int ACK_PENDING_BIT  = 0;
   localparam int ACK_OVERRUN_BIT  = 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/timer_event.sv
// Timer event/interrupt block: run tracking FSM, pending/overrun flags, saturating expiry count.
// Optional compare-match event enabled by defining TIMER_EVENT_COMPARE_EN.
module timer_event
   import timer_event_pkg::*;
#(
   parameter int CNT_WIDTH = 8
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        cs,
   input  logic        we,
   input  logic [7:0]  address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   input  logic        timer_running,
   input  logic        timer_stop,
   input  logic [31:0] curr_timer,
   output logic        irq
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   state_e               state_q, state_d;
   logic                 stop_seen_q, stop_seen_d;
   logic                 pending_q, pending_d;
   logic                 overrun_q, overrun_d;
   logic                 irq_en_q, irq_en_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;

   logic        wr_en, rd_en, ctrl_wr, cnt_wr, ack_wr;
   logic        ack_hit, run_entry, expiry, cmp_event, event_any, cmp_en;
   logic [31:0] compare_rd;

   assign ready     = cs;
   assign wr_en     = cs & we;
   assign rd_en     = cs & ~we;
   assign ctrl_wr   = wr_en && (address == ADDR_CTRL);
   assign cnt_wr    = wr_en && (address == ADDR_COUNT);
   assign ack_wr    = wr_en && (address == ADDR_ACK);
   assign ack_hit   = ack_wr && (write_data[ACK_PENDING_BIT] || write_data[ACK_OVERRUN_BIT]);
   assign run_entry = (state_q == ST_IDLE) && timer_running;
   assign event_any = expiry | cmp_event;
   assign irq       = pending_q & irq_en_q;

   always_comb begin
      state_d     = state_q;
      stop_seen_d = stop_seen_q;
      expiry      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (timer_running) begin
               state_d     = ST_RUN;
               stop_seen_d = 1'b0;
            end
         end
         ST_RUN: begin
            if (timer_stop) stop_seen_d = 1'b1;
            if (!timer_running) begin
               state_d = ST_IDLE;
               expiry  = !stop_seen_q && !timer_stop;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef TIMER_EVENT_COMPARE_EN
   logic [31:0] compare_q, compare_d;
   logic        cmp_en_q, cmp_en_d;
   logic        match_done_q, match_done_d;

   assign cmp_en     = cmp_en_q;
   assign compare_rd = compare_q;
   // One compare event per run: match_done blocks repeats until the next run starts.
   assign cmp_event  = (state_q == ST_RUN) && cmp_en_q && !match_done_q && (curr_timer == compare_q);

   always_comb begin
      compare_d    = (wr_en && (address == ADDR_COMPARE)) ? write_data : compare_q;
      cmp_en_d     = ctrl_wr ? write_data[CTRL_CMP_EN_BIT] : cmp_en_q;
      match_done_d = match_done_q;
      if (run_entry)      match_done_d = 1'b0;
      else if (cmp_event) match_done_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         compare_q    <= '0;
         cmp_en_q     <= 1'b0;
         match_done_q <= 1'b0;
      end else begin
         compare_q    <= compare_d;
         cmp_en_q     <= cmp_en_d;
         match_done_q <= match_done_d;
      end
   end
`else
   logic unused_inputs;

   assign cmp_en        = 1'b0;
   assign compare_rd    = '0;
   assign cmp_event     = 1'b0;
   assign unused_inputs = ^{curr_timer, write_data[31:2]};
`endif

   always_comb begin
      irq_en_d  = ctrl_wr ? write_data[CTRL_IRQ_EN_BIT] : irq_en_q;
      pending_d = pending_q;
      overrun_d = overrun_q;
      // A coincident ACK consumes the earlier event, so it cannot also flag an overrun.
      if (event_any) begin
         pending_d = 1'b1;
         if (pending_q && !ack_hit) overrun_d = 1'b1;
      end else if (ack_wr) begin
         if (write_data[ACK_PENDING_BIT]) pending_d = 1'b0;
         if (write_data[ACK_OVERRUN_BIT]) overrun_d = 1'b0;
      end

      count_d = count_q;
      if (cnt_wr)
         count_d = expiry ? CNT_WIDTH'(1) : '0;
      else if (expiry && (count_q != CNT_MAX))
         count_d = count_q + 1'b1;
   end

   always_comb begin
      read_data = '0;
      if (rd_en) begin
         case (address)
            ADDR_CTRL: begin
               read_data[CTRL_IRQ_EN_BIT] = irq_en_q;
               read_data[CTRL_CMP_EN_BIT] = cmp_en;
            end
            ADDR_STATUS: begin
               read_data[STAT_PENDING_BIT] = pending_q;
               read_data[STAT_OVERRUN_BIT] = overrun_q;
               read_data[STAT_RUN_BIT]     = (state_q == ST_RUN);
            end
            ADDR_COUNT:   read_data[CNT_WIDTH-1:0] = count_q;
            ADDR_COMPARE: read_data = compare_rd;
            default:      read_data = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         stop_seen_q <= 1'b0;
         pending_q   <= 1'b0;
         overrun_q   <= 1'b0;
         irq_en_q    <= 1'b0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         stop_seen_q <= stop_seen_d;
         pending_q   <= pending_d;
         overrun_q   <= overrun_d;
         irq_en_q    <= irq_en_d;
         count_q     <= count_d;
      end
   end

endmodule

// File: tb/tb_timer_event.sv
// Scoreboard bench for timer_event: run-level reference model, reads checked by a separate monitor.
module tb_timer_event;
   import timer_event_pkg::*;

   localparam int CW   = 2;
   localparam int CMAX = 3;

   logic        clk, reset, cs, we, ready, irq, timer_running, timer_stop;
   logic [7:0]  address;
   logic [31:0] write_data, read_data, curr_timer;

   timer_event #(.CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .cs(cs), .we(we), .address(address),
      .write_data(write_data), .read_data(read_data), .ready(ready),
      .timer_running(timer_running), .timer_stop(timer_stop),
      .curr_timer(curr_timer), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
      logic        irq;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model state (register-level view, updated once per transaction or run)
   bit          m_pending, m_overrun, m_irq_en, m_cmp_en;
   int          m_count;
   logic [31:0] m_compare;

   function automatic logic [31:0] model_read(input logic [7:0] a, input bit running);
      logic [31:0] v;
      v = 32'd0;
      if (a == ADDR_CTRL)         v = {30'd0, m_cmp_en, m_irq_en};
      else if (a == ADDR_STATUS)  v = {29'd0, running, m_overrun, m_pending};
      else if (a == ADDR_COUNT)   v = 32'(m_count);
      else if (a == ADDR_COMPARE) v = m_compare;
      return v;
   endfunction

   function automatic void model_write(input logic [7:0] a, input logic [31:0] d);
      if (a == ADDR_CTRL) begin
         m_irq_en = d[0];
`ifdef TIMER_EVENT_COMPARE_EN
         m_cmp_en = d[1];
`endif
      end else if (a == ADDR_ACK) begin
         if (d[0]) m_pending = 1'b0;
         if (d[1]) m_overrun = 1'b0;
      end else if (a == ADDR_COUNT) begin
         m_count = 0;
      end else if (a == ADDR_COMPARE) begin
`ifdef TIMER_EVENT_COMPARE_EN
         m_compare = d;
`endif
      end
   endfunction

   function automatic void model_reset();
      m_pending = 0; m_overrun = 0; m_irq_en = 0; m_cmp_en = 0;
      m_count = 0; m_compare = 32'd0;
   endfunction

   function automatic void push_exp(input logic [7:0] a, input logic [31:0] d);
      exp_t e;
      e.addr = a;
      e.data = d;
      e.irq  = m_pending & m_irq_en;
      sb_q.push_back(e);
   endfunction

   task automatic drive(input bit c, input bit w, input logic [7:0] a, input logic [31:0] d,
                        input bit run, input bit stp, input logic [31:0] ct);
      @(posedge clk);
      #1;
      cs = c; we = w; address = a; write_data = d;
      timer_running = run; timer_stop = stp; curr_timer = ct;
   endtask

   task automatic rd(input logic [7:0] a);
      drive(1'b1, 1'b0, a, 32'd0, 1'b0, 1'b0, $urandom);
      push_exp(a, model_read(a, 1'b0));
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      drive(1'b1, 1'b1, a, d, 1'b0, 1'b0, $urandom);
      model_write(a, d);
   endtask

   // One run of n RUN cycles; stop_at is the step carrying timer_stop, coinc selects
   // an ACK (1) or COUNT (2) write landing in the same cycle as the falling edge.
   task automatic run(input int n, input int stop_at, input int coinc, input logic [31:0] cdata);
      bit expire, ack_hit;
      for (int i = 0; i <= n; i++) begin
         bit          c, w, mid;
         logic [7:0]  a;
         logic [31:0] d;
         c = 0; w = 0; a = 8'h00; d = 32'd0;
         mid = (i == 2) && (n >= 3);
         if (i == n && coinc != 0) begin
            c = 1; w = 1; d = cdata;
            a = (coinc == 1) ? ADDR_ACK : ADDR_COUNT;
         end else if (mid) begin
            c = 1; a = ADDR_STATUS;
         end
         drive(c, w, a, d, i < n, i == stop_at, $urandom);
         if (mid && !w) push_exp(ADDR_STATUS, model_read(ADDR_STATUS, 1'b1));
      end
      expire  = !(stop_at >= 1 && stop_at <= n);
      ack_hit = (coinc == 1) && (cdata[1:0] != 2'b00);
      if (expire) begin
         if (!ack_hit) m_overrun = m_overrun | m_pending;
         m_pending = 1'b1;
         if (coinc == 2) m_count = 1;
         else if (m_count < CMAX) m_count = m_count + 1;
      end else if (coinc == 1) begin
         model_write(ADDR_ACK, cdata);
      end else if (coinc == 2) begin
         model_write(ADDR_COUNT, cdata);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         n_cmp++;
         if (ready !== cs) begin
            n_bad++;
            $display("FAIL ready: got %b expected %b", ready, cs);
         end
         if (cs && we) begin
            n_cmp++;
            if (read_data !== 32'd0) begin
               n_bad++;
               $display("FAIL read_on_write: got %h expected 0", read_data);
            end
         end else if (cs) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_read addr %h: got %h, no expectation queued", address, read_data);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               if (read_data !== e.data || irq !== e.irq || address !== e.addr) begin
                  n_bad++;
                  $display("FAIL read addr %h: got data %h irq %b expected data %h irq %b",
                           address, read_data, irq, e.data, e.irq);
               end else begin
                  $display("read addr %h data %h irq %b ok", address, read_data, irq);
               end
            end
         end
      end
   end

   initial begin
      logic [31:0] seq [0:8];
      reset = 1'b1; cs = 0; we = 0; address = 0; write_data = 0;
      timer_running = 0; timer_stop = 0; curr_timer = 0;
      model_reset();
      #22 reset = 1'b0;

      rd(ADDR_CTRL); rd(ADDR_STATUS); rd(ADDR_COUNT); rd(ADDR_COMPARE); rd(ADDR_ACK);

      wr(ADDR_CTRL, 32'h1);
      run(10, 99, 0, 0);
      rd(ADDR_STATUS); rd(ADDR_COUNT);

      wr(ADDR_ACK, 32'h3); wr(ADDR_COUNT, 32'h0);
      run(10, 5, 0, 0);
      rd(ADDR_STATUS); rd(ADDR_COUNT);

      run(4, 99, 0, 0); run(4, 99, 0, 0);
      rd(ADDR_STATUS);
      wr(ADDR_ACK, 32'h3);
      rd(ADDR_STATUS);

      run(4, 99, 1, 32'h1);
      rd(ADDR_STATUS); rd(ADDR_COUNT);

      run(2, 99, 0, 0); run(1, 0, 0, 0);
      rd(ADDR_COUNT); rd(ADDR_STATUS);
      run(3, 99, 2, 32'h5);
      rd(ADDR_COUNT);
      run(3, 3, 2, 32'h0);
      rd(ADDR_COUNT);

      wr(ADDR_ACK, 32'h2); rd(ADDR_STATUS);
      wr(ADDR_ACK, 32'h0); rd(ADDR_STATUS);

      wr(ADDR_CTRL, 32'h3); rd(ADDR_CTRL);
      wr(ADDR_COMPARE, 32'h55); rd(ADDR_COMPARE);
      wr(ADDR_CTRL, 32'h1);
      rd(8'h0d); rd(8'h00); rd(8'hff);

`ifdef TIMER_EVENT_COMPARE_EN
      wr(ADDR_ACK, 32'h3);
      wr(ADDR_CTRL, 32'h3);
      wr(ADDR_COMPARE, 32'h20);
      seq[0] = 32'h40; seq[1] = 32'h38; seq[2] = 32'h30; seq[3] = 32'h28;
      seq[4] = 32'h20; seq[5] = 32'h20; seq[6] = 32'h20; seq[7] = 32'h18; seq[8] = 32'h18;
      for (int i = 0; i <= 8; i++) begin
         drive(i == 7, 1'b0, (i == 7) ? ADDR_STATUS : 8'h00, 32'd0, i < 8, i == 8, seq[i]);
         if (i == 4) begin
            m_overrun = m_overrun | m_pending;
            m_pending = 1'b1;
         end
         if (i == 7) push_exp(ADDR_STATUS, model_read(ADDR_STATUS, 1'b1));
      end
      rd(ADDR_STATUS); rd(ADDR_COUNT);
      wr(ADDR_CTRL, 32'h1);
`else
      seq[0] = 32'd0;
      for (int i = 1; i <= 8; i++) seq[i] = seq[0];
`endif

      for (int it = 0; it < 60; it++) begin
         int          op;
         logic [31:0] d;
         op = $urandom_range(0, 6);
         d  = $urandom;
         case (op)
            0, 1: run($urandom_range(1, 6), $urandom_range(0, 8), $urandom_range(0, 2), d);
            2: begin d[1] = 1'b0; wr(ADDR_CTRL, d); end
            3: wr(ADDR_ACK, d);
            4: wr(ADDR_COUNT, d);
            5: wr(ADDR_COMPARE, d);
            default: rd(8'($urandom_range(0, 15)));
         endcase
         rd(ADDR_STATUS); rd(ADDR_COUNT);
      end

      // Asynchronous reset in the middle of a run with the interrupt asserted
      run(3, 99, 0, 0);
      wr(ADDR_CTRL, 32'h1);
      drive(0, 0, 8'h00, 32'd0, 1'b1, 1'b0, 32'd0);
      n_cmp++;
      if (irq !== 1'b1) begin
         n_bad++;
         $display("FAIL irq_before_reset: got %b expected 1", irq);
      end
      drive(0, 0, 8'h00, 32'd0, 1'b1, 1'b0, 32'd0);
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if (irq !== 1'b0) begin
         n_bad++;
         $display("FAIL irq_async_reset: got %b expected 0", irq);
      end else $display("async reset: irq %b ok", irq);
      timer_running = 1'b0;
      model_reset();
      #20;
      @(negedge clk);
      reset = 1'b0;
      rd(ADDR_CTRL); rd(ADDR_STATUS); rd(ADDR_COUNT); rd(ADDR_COMPARE);
      drive(0, 0, 8'h00, 32'd0, 1'b0, 1'b0, 32'd0);

      for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(posedge clk);
      if (sb_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_drain: %0d expected reads never observed, expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
